// File: rtl/alu_uart_pkg.sv
// Shared definitions for the UART-attached ALU link: FSM states, frame sizes,
// opcode encodings and the command-frame byte selector.
package alu_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    GAP,
    WAIT_RX,
    DONE
  } state_t;

  localparam int CMD_BYTES  = 5;
  localparam int RESP_BYTES = 2;
  localparam int OP_W       = 3;

  localparam logic [OP_W-1:0] OP_ADD = 3'd0;
  localparam logic [OP_W-1:0] OP_SUB = 3'd1;
  localparam logic [OP_W-1:0] OP_AND = 3'd2;
  localparam logic [OP_W-1:0] OP_OR  = 3'd3;
  localparam logic [OP_W-1:0] OP_XOR = 3'd4;
  localparam logic [OP_W-1:0] OP_SLT = 3'd5;
  localparam logic [OP_W-1:0] OP_SLL = 3'd6;
  localparam logic [OP_W-1:0] OP_SRL = 3'd7;

  // Command frame is big-endian A, big-endian B, then the zero-padded opcode.
  function automatic logic [7:0] cmd_byte(input logic [15:0]     a,
                                          input logic [15:0]     b,
                                          input logic [OP_W-1:0] op,
                                          input logic [2:0]      idx);
    case (idx)
      3'd0:    cmd_byte = a[15:8];
      3'd1:    cmd_byte = a[7:0];
      3'd2:    cmd_byte = b[15:8];
      3'd3:    cmd_byte = b[7:0];
      default: cmd_byte = {5'b0, op};
    endcase
  endfunction

endpackage

// File: rtl/alu_uart_timeout.sv
// Loadable down-counter with a terminal-count flag; o_tc is high while the
// count sits at zero. Shared between host and bridge-side controllers.
module alu_uart_timeout #(
  parameter int unsigned LOAD_VALUE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  input  logic i_en,
  output logic o_tc
);

  localparam int unsigned CW = (LOAD_VALUE > 1) ? $clog2(LOAD_VALUE + 1) : 1;

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= CW'(LOAD_VALUE);
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - CW'(1);
    end
  end

  assign o_tc = (r_count == '0);

endmodule

// File: rtl/alu_uart_host.sv
// Host-side ALU command initiator: serializes one request into a 5-byte frame
// over a byte-level uart_tx and returns the 2-byte result or a timeout error.
module alu_uart_host
  import alu_uart_pkg::*;
#(
  parameter int          N              = 16,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [N-1:0]    req_a,
  input  logic [N-1:0]    req_b,
  input  logic [OP_W-1:0] req_op,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [N-1:0]    resp_result,
  output logic            resp_timeout,
  output logic [7:0]      tx_data,
  output logic            tx_start,
  input  logic            tx_busy,
  input  logic [7:0]      rx_data,
  input  logic            rx_valid
);

  state_t          r_state, w_state_next;
  logic [2:0]      r_idx, w_idx_next;
  logic [N-1:0]    r_a, w_a_next;
  logic [N-1:0]    r_b, w_b_next;
  logic [OP_W-1:0] r_op, w_op_next;
  logic [7:0]      r_hi, w_hi_next;
  logic            r_guard, w_guard_next;
  logic [7:0]      r_tx_data, w_tx_data_next;
  logic            r_tx_start, w_tx_start_next;
  logic            r_resp_valid, w_resp_valid_next;
  logic [N-1:0]    r_resp_result, w_resp_result_next;
  logic            r_resp_timeout, w_resp_timeout_next;

  logic w_to_load;
  logic w_to_en;
  logic w_to_tc;

  // Loaded with TIMEOUT_CYCLES-1 so the terminal count is reached after
  // exactly TIMEOUT_CYCLES silent cycles following entry or the last byte.
  alu_uart_timeout #(
    .LOAD_VALUE(TIMEOUT_CYCLES - 1)
  ) u_timeout (
    .clk   (clk),
    .rst_n (rst),
    .i_load(w_to_load),
    .i_en  (w_to_en),
    .o_tc  (w_to_tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= IDLE;
      r_idx          <= '0;
      r_a            <= '0;
      r_b            <= '0;
      r_op           <= '0;
      r_hi           <= '0;
      r_guard        <= 1'b0;
      r_tx_data      <= '0;
      r_tx_start     <= 1'b0;
      r_resp_valid   <= 1'b0;
      r_resp_result  <= '0;
      r_resp_timeout <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_idx          <= w_idx_next;
      r_a            <= w_a_next;
      r_b            <= w_b_next;
      r_op           <= w_op_next;
      r_hi           <= w_hi_next;
      r_guard        <= w_guard_next;
      r_tx_data      <= w_tx_data_next;
      r_tx_start     <= w_tx_start_next;
      r_resp_valid   <= w_resp_valid_next;
      r_resp_result  <= w_resp_result_next;
      r_resp_timeout <= w_resp_timeout_next;
    end
  end

  always_comb begin
    w_state_next        = r_state;
    w_idx_next          = r_idx;
    w_a_next            = r_a;
    w_b_next            = r_b;
    w_op_next           = r_op;
    w_hi_next           = r_hi;
    w_guard_next        = r_guard;
    w_tx_data_next      = r_tx_data;
    w_tx_start_next     = 1'b0;
    w_resp_valid_next   = r_resp_valid;
    w_resp_result_next  = r_resp_result;
    w_resp_timeout_next = r_resp_timeout;
    w_to_load           = 1'b0;
    w_to_en             = 1'b0;

    case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_a_next     = req_a;
          w_b_next     = req_b;
          w_op_next    = req_op;
          w_idx_next   = '0;
          w_state_next = SEND;
        end
      end
      SEND: begin
        if (!tx_busy) begin
          w_tx_data_next  = cmd_byte(r_a, r_b, r_op, r_idx);
          w_tx_start_next = 1'b1;
          w_guard_next    = 1'b1;
          w_state_next    = GAP;
        end
      end
      GAP: begin
        // The first GAP cycle is the one carrying tx_start; uart_tx cannot
        // have raised busy yet, so it must not be read as "done".
        if (r_guard) begin
          w_guard_next = 1'b0;
        end else if (!tx_busy) begin
          if (r_idx == 3'(CMD_BYTES - 1)) begin
            w_idx_next   = '0;
            w_to_load    = 1'b1;
            w_state_next = WAIT_RX;
          end else begin
            w_idx_next   = r_idx + 3'd1;
            w_state_next = SEND;
          end
        end
      end
      WAIT_RX: begin
        // A byte on the terminal-count cycle takes priority over the timeout.
        if (rx_valid) begin
          w_to_load = 1'b1;
          if (r_idx == 3'(RESP_BYTES - 1)) begin
            w_resp_result_next  = {r_hi, rx_data};
            w_resp_timeout_next = 1'b0;
            w_resp_valid_next   = 1'b1;
            w_state_next        = DONE;
          end else begin
            w_hi_next  = rx_data;
            w_idx_next = r_idx + 3'd1;
          end
        end else if (w_to_tc) begin
          w_resp_result_next  = '0;
          w_resp_timeout_next = 1'b1;
          w_resp_valid_next   = 1'b1;
          w_state_next        = DONE;
        end else begin
          w_to_en = 1'b1;
        end
      end
      DONE: begin
        if (resp_ready) begin
          w_resp_valid_next   = 1'b0;
          w_resp_timeout_next = 1'b0;
          w_state_next        = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign req_ready    = (r_state == IDLE);
  assign resp_valid   = r_resp_valid;
  assign resp_result  = r_resp_result;
  assign resp_timeout = r_resp_timeout;
  assign tx_data      = r_tx_data;
  assign tx_start     = r_tx_start;

endmodule

// File: doc/alu_uart_host.md
Name: alu_uart_host

Overview:
- Host-side command initiator for the UART-attached ALU, i.e. the other end of the serial link from the ALU bridge.
- Accepts one ALU request (A, B, op) on a valid/ready interface and serializes it into a 5-byte command frame through a byte-level uart_tx.
- Collects the 2-byte result frame from a byte-level uart_rx and returns the signed 16-bit result, or a timeout error, on a valid/ready response interface.
- Sits in test harnesses and multi-board setups alongside uart_tx/uart_rx instances.

Parameters:
- N, 16, operand/result width in bits; fixed at 16 for this frame format.
- TIMEOUT_CYCLES, 2000000, clk cycles allowed in WAIT_RX before abort; must be >= 1.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE
- req_a  in  16  signed operand A
- req_b  in  16  signed operand B
- req_op  in  3  ALU opcode
- resp_valid  out  1  response available
- resp_ready  in  1  consumer accepts response
- resp_result  out  16  signed result
- resp_timeout  out  1  response is a timeout error; resp_result is 0
- tx_data  out  8  byte to uart_tx
- tx_start  out  1  one-cycle start pulse to uart_tx
- tx_busy  in  1  uart_tx busy
- rx_data  in  8  byte from uart_rx
- rx_valid  in  1  one-cycle strobe from uart_rx

Behaviour:
- Reset (rst low, asynchronous):
  - State is IDLE.
  - Outputs req_ready=1, resp_valid=0, resp_result=0, resp_timeout=0, tx_start=0, tx_data=0.
  - Byte index, timeout counter and capture registers are cleared.
  - Reset mid-frame abandons the frame with no partial response. The far end resynchronizes by its own framing; that is outside this block.
- Command frame byte order:
  - 0: A[15:8]
  - 1: A[7:0]
  - 2: B[15:8]
  - 3: B[7:0]
  - 4: {5'b0, op}
- Response frame: R[15:8] then R[7:0].
- IDLE:
  - On req_valid && req_ready, latch A, B and op, set idx=0, go to SEND.
  - req_ready is 0 in every state other than IDLE.
- SEND:
  - When tx_busy==0, drive tx_data=byte[idx] and pulse tx_start for exactly 1 cycle, then go to GAP.
- GAP:
  - Hold for 1 guard cycle so tx_busy can assert.
  - Then wait until tx_busy==0.
  - If idx==4: clear idx and the timeout counter, go to WAIT_RX.
  - Otherwise: idx+1, go to SEND.
  - Minimum spacing between tx_start pulses is 2 cycles plus uart_tx busy time.
- WAIT_RX:
  - Each rx_valid captures rx_data: idx 0 goes to hi, idx 1 goes to lo.
  - After the lo byte, resp_result={hi,lo}, resp_timeout=0, resp_valid=1 in the next cycle, go to DONE.
  - The timeout counter increments every cycle in WAIT_RX and resets to 0 on each received byte, so the timeout is an inter-byte limit.
  - When the counter reaches TIMEOUT_CYCLES-1 with no rx_valid in that cycle: resp_timeout=1, resp_result=0, resp_valid=1, go to DONE.
  - If rx_valid coincides with the terminal count, the byte wins and the counter resets.
- DONE:
  - Hold resp_* stable while resp_valid && !resp_ready.
  - On resp_ready, clear resp_valid and resp_timeout and go to IDLE. req_ready rises the following cycle; there is no same-cycle response-to-request bypass.
- rx_valid outside WAIT_RX is discarded with no state change (stray or late bytes).
- Latency: the response is valid 1 cycle after the second rx_valid strobe.

Decomposition:
- Shared package alu_uart_pkg holds:
  - state encoding: IDLE, SEND, GAP, WAIT_RX, DONE
  - CMD_BYTES=5, RESP_BYTES=2
  - opcode width 3
  - the opcode constants already used by the ALU core
- Natural sub-module: alu_uart_timeout, a loadable/clearable down-counter with a terminal-count flag, reusable by the bridge-side controller.

Test Plan:
- Reset: hold rst=0 with tx_busy=0 -> req_ready=1, tx_start=0, resp_valid=0. Assert rst=0 mid-SEND -> returns to IDLE immediately with no further tx_start.
- Basic transaction: A=16'h1234, B=16'h0005, op=3'd0, uart_tx model busy 10 cycles per byte -> tx_data sequence 12,34,00,05,00, each with a single-cycle tx_start. Then rx bytes 12,39 -> resp_result=16'h1239, resp_timeout=0.
- Negative operands: A=16'hFFFE (-2), B=16'h0003, op=3'd1 -> bytes FF,FE,00,03,01. Rx FF,FB -> resp_result=16'hFFFB (-5).
- Backpressure: hold resp_ready=0 for 50 cycles -> resp_valid and resp_result stable. req_valid is ignored (req_ready=0) until 1 cycle after the resp_ready handshake.
- Timeout: TIMEOUT_CYCLES=100, send a full frame, reply with only one byte -> resp_valid with resp_timeout=1, resp_result=0 exactly 100 cycles after that byte. A late byte arriving in DONE or IDLE is ignored.
- Boundary: rx_valid on the terminal-count cycle -> the byte is accepted and there is no timeout. rx_valid during SEND -> dropped, and the frame still completes correctly.
